// File: rtl/spike_count_window_pkg.sv
// Shared definitions for the spike-count window and the downstream max-spike classifier.
package spike_count_window_pkg;

   localparam int SNN_NUM_CLASSES = 10;
   localparam int SNN_COUNT_W     = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/spike_count_window_if.sv
// Control, spike input and published-count signals of the spike-count window.
interface spike_count_window_if
   import spike_count_window_pkg::*;
#(
   parameter int NUM_CLASSES = SNN_NUM_CLASSES,
   parameter int COUNT_W     = SNN_COUNT_W
);
   logic                           start;
   logic                           step_valid;
   logic [NUM_CLASSES-1:0]         spikes;
   logic                           busy;
   logic [NUM_CLASSES*COUNT_W-1:0] counts;
   logic                           counts_valid;
   logic                           overflow;

   modport master (
      output start, step_valid, spikes,
      input  busy, counts, counts_valid, overflow
   );

   modport slave (
      input  start, step_valid, spikes,
      output busy, counts, counts_valid, overflow
   );
endinterface

// File: rtl/spike_count_window_sat_counter.sv
// Saturating up-counter; sat flags an increment that was clipped at the maximum value.
module sat_counter
   import spike_count_window_pkg::*;
#(
   parameter int COUNT_W = SNN_COUNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               inc,
   output logic [COUNT_W-1:0] q,
   output logic               sat
);

   assign sat = inc && (q == '1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (inc && !sat)
         q <= q + COUNT_W'(1);
   end

endmodule

// File: rtl/spike_count_window.sv
// Counts per-class spikes over WINDOW_LEN accepted timesteps and publishes saturated counts.
module spike_count_window
   import spike_count_window_pkg::*;
#(
   parameter int NUM_CLASSES = SNN_NUM_CLASSES,
   parameter int COUNT_W     = SNN_COUNT_W,
   parameter int WINDOW_LEN  = 100,
   parameter int STEP_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   spike_count_window_if.slave  bus
);

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WINDOW_LEN - 1);

   state_t                         state, state_nx;
   logic   [STEP_W-1:0]            step_idx;
   logic                           sat_flag;
   logic                           clr;
   logic                           step_en;
   logic   [NUM_CLASSES-1:0]       inc_vec;
   logic   [NUM_CLASSES-1:0]       sat_vec;
   logic   [NUM_CLASSES*COUNT_W-1:0] work;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // A restart in COUNT wins over a coincident step, which is dropped.
   always_comb begin
      state_nx = state;
      clr      = 1'b0;
      step_en  = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               clr      = 1'b1;
               state_nx = COUNT;
            end
         end
         COUNT: begin
            if (bus.start) begin
               clr = 1'b1;
            end else if (bus.step_valid) begin
               step_en = 1'b1;
               if (step_idx == LAST_STEP)
                  state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_cnt
      assign inc_vec[i] = step_en & bus.spikes[i];
      sat_counter #(.COUNT_W(COUNT_W)) u_cnt (
         .clk (clk),
         .rst (rst),
         .clr (clr),
         .inc (inc_vec[i]),
         .q   (work[i*COUNT_W +: COUNT_W]),
         .sat (sat_vec[i])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_idx <= '0;
         sat_flag <= 1'b0;
      end else if (clr) begin
         step_idx <= '0;
         sat_flag <= 1'b0;
      end else if (step_en) begin
         step_idx <= step_idx + STEP_W'(1);
         if (|sat_vec)
            sat_flag <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.counts       <= '0;
         bus.overflow     <= 1'b0;
         bus.counts_valid <= 1'b0;
      end else begin
         bus.counts_valid <= (state == DONE);
         if (state == DONE) begin
            bus.counts   <= work;
            bus.overflow <= sat_flag;
         end
      end
   end

   assign bus.busy = (state == COUNT);

endmodule
